// File: rtl/frogger_game_seq_if.sv
// -----------------------------------------------------------------------------
// frogger_game_seq_if
//
// Bundles the game sequencer's player/collision inputs and its display/HUD
// outputs. Clock and reset are not part of the bundle.
//
//   master : drives i_Start, the four direction levels and i_Hazard_Hit;
//            observes frog position, round state, lives, score and level.
//   slave  : the sequencer itself (frogger_game_seq).
//
//   i_Start       start/restart request, level
//   i_Up_Mvt      up request (Y-1), debounced level
//   i_Down_Mvt    down request (Y+1), debounced level
//   i_Left_Mvt    left request (X-1), debounced level
//   i_Right_Mvt   right request (X+1), debounced level
//   i_Hazard_Hit  frog tile overlaps a car / water this clock
//   o_Frogger_X   frog column
//   o_Frogger_Y   frog row (0 = goal row)
//   o_State       0 IDLE, 1 PLAY, 2 DYING, 3 SCORED, 4 GAME_OVER
//   o_Game_Active high in PLAY, DYING, SCORED
//   o_Death_Flash high throughout DYING
//   o_Lives       remaining lives
//   o_Score       goals reached, saturates at 99
//   o_Level       difficulty level, saturates at 7
// -----------------------------------------------------------------------------
interface frogger_game_seq_if;
  logic       i_Start;
  logic       i_Up_Mvt;
  logic       i_Down_Mvt;
  logic       i_Left_Mvt;
  logic       i_Right_Mvt;
  logic       i_Hazard_Hit;
  logic [5:0] o_Frogger_X;
  logic [5:0] o_Frogger_Y;
  logic [2:0] o_State;
  logic       o_Game_Active;
  logic       o_Death_Flash;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [2:0] o_Level;

  modport master (
    output i_Start, i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt, i_Hazard_Hit,
    input  o_Frogger_X, o_Frogger_Y, o_State, o_Game_Active, o_Death_Flash,
           o_Lives, o_Score, o_Level
  );

  modport slave (
    input  i_Start, i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt, i_Hazard_Hit,
    output o_Frogger_X, o_Frogger_Y, o_State, o_Game_Active, o_Death_Flash,
           o_Lives, o_Score, o_Level
  );
endinterface

// File: rtl/frogger_game_seq.sv
// -----------------------------------------------------------------------------
// frogger_game_seq
//
// Game-level sequencer: owns the frog's tile position and the round state.
// Direction levels are arbitrated (Up > Down > Left > Right) into single-tile
// moves limited by a repeat cooldown; hazard hits end the current life; the
// goal row scores a point and raises the level. Flow:
//   IDLE -> PLAY -> (DYING | SCORED) -> PLAY ... -> GAME_OVER -> PLAY
//
// Ports:
//   i_Clk    system clock
//   i_Rst_L  asynchronous active-low reset
//   bus      frogger_game_seq_if.slave (inputs from the player / collision
//            logic, registered outputs to the frog draw logic and HUD)
// -----------------------------------------------------------------------------
module frogger_game_seq #(
  parameter int GRID_W        = 20,
  parameter int GRID_H        = 15,
  parameter int START_X       = 10,
  parameter int START_Y       = 14,
  parameter int START_LIVES   = 3,
  parameter int MOVE_COOLDOWN = 6250000,
  parameter int DEATH_CYCLES  = 25000000,
  parameter int SCORE_CYCLES  = 12500000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  frogger_game_seq_if.slave  bus
);

  // Counter widths; a width of at least 1 keeps degenerate parameters legal.
  localparam int CD_W      = (MOVE_COOLDOWN > 1) ? $clog2(MOVE_COOLDOWN) : 1;
  localparam int PHASE_MAX = (DEATH_CYCLES > SCORE_CYCLES) ? DEATH_CYCLES : SCORE_CYCLES;
  localparam int TM_W      = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [5:0]      X_SPAWN    = 6'(START_X);
  localparam logic [5:0]      Y_SPAWN    = 6'(START_Y);
  localparam logic [5:0]      X_LAST     = 6'(GRID_W - 1);
  localparam logic [5:0]      Y_LAST     = 6'(GRID_H - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(START_LIVES);
  localparam logic [CD_W-1:0] CD_RELOAD  = CD_W'(MOVE_COOLDOWN - 1);
  localparam logic [TM_W-1:0] DEATH_LAST = TM_W'(DEATH_CYCLES - 1);
  localparam logic [TM_W-1:0] SCORE_LAST = TM_W'(SCORE_CYCLES - 1);
  localparam logic [6:0]      SCORE_SAT  = 7'd99;
  localparam logic [2:0]      LEVEL_SAT  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_SCORED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      x_q, x_d;
  logic [5:0]      y_q, y_d;
  logic [1:0]      lives_q, lives_d;
  logic [6:0]      score_q, score_d;
  logic [2:0]      level_q, level_d;
  logic [CD_W-1:0] cd_q, cd_d;       // clocks until the next move may be accepted
  logic [TM_W-1:0] tm_q, tm_d;       // clocks already spent in DYING / SCORED
  logic            active_q, active_d;
  logic            flash_q, flash_d;
  logic            any_dir;

  assign any_dir = bus.i_Up_Mvt | bus.i_Down_Mvt | bus.i_Left_Mvt | bus.i_Right_Mvt;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    cd_d    = cd_q;
    tm_d    = tm_q;

    case (state_q)
      ST_IDLE: begin
        x_d = X_SPAWN;
        y_d = Y_SPAWN;
        if (bus.i_Start) begin
          // Treated as a fresh game so a recovery into IDLE starts cleanly.
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
          level_d = '0;
          cd_d    = '0;
          tm_d    = '0;
        end
      end

      ST_PLAY: begin
        if (bus.i_Hazard_Hit) begin
          // A hit wins over everything, including a move in the same clock.
          state_d = ST_DYING;
          lives_d = (lives_q != '0) ? lives_q - 2'd1 : '0;
          tm_d    = '0;
        end else if (y_q == '0) begin
          // Frog sits on the goal row: the round is won, no further moves.
          state_d = ST_SCORED;
          score_d = (score_q >= SCORE_SAT) ? SCORE_SAT : score_q + 7'd1;
          level_d = (level_q == LEVEL_SAT) ? LEVEL_SAT : level_q + 3'd1;
          tm_d    = '0;
        end else if (cd_q == '0) begin
          if (any_dir) begin
            // The cooldown reloads even when the step is blocked by an edge,
            // so pushing into a wall paces itself like a real move.
            cd_d = CD_RELOAD;
            if (bus.i_Up_Mvt) begin
              if (y_q != '0) y_d = y_q - 6'd1;
            end else if (bus.i_Down_Mvt) begin
              if (y_q != Y_LAST) y_d = y_q + 6'd1;
            end else if (bus.i_Left_Mvt) begin
              if (x_q != '0) x_d = x_q - 6'd1;
            end else begin
              if (x_q != X_LAST) x_d = x_q + 6'd1;
            end
          end
        end else begin
          cd_d = cd_q - CD_W'(1);
        end
      end

      ST_DYING: begin
        if (tm_q >= DEATH_LAST) begin
          tm_d = '0;
          if (lives_q == '0) begin
            // Position is left where the frog died, for the game-over screen.
            state_d = ST_GAME_OVER;
          end else begin
            state_d = ST_PLAY;
            x_d     = X_SPAWN;
            y_d     = Y_SPAWN;
            cd_d    = '0;
          end
        end else begin
          tm_d = tm_q + TM_W'(1);
        end
      end

      ST_SCORED: begin
        if (tm_q >= SCORE_LAST) begin
          state_d = ST_PLAY;
          tm_d    = '0;
          x_d     = X_SPAWN;
          y_d     = Y_SPAWN;
          cd_d    = '0;
        end else begin
          tm_d = tm_q + TM_W'(1);
        end
      end

      ST_GAME_OVER: begin
        if (bus.i_Start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
          level_d = '0;
          x_d     = X_SPAWN;
          y_d     = Y_SPAWN;
          cd_d    = '0;
          tm_d    = '0;
        end
      end

      default: begin
        // Unused encodings 5..7 fall back to IDLE.
        state_d = ST_IDLE;
        x_d     = X_SPAWN;
        y_d     = Y_SPAWN;
        cd_d    = '0;
        tm_d    = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register together
  // with o_State instead of lagging one clock behind it.
  always_comb begin
    active_d = (state_d == ST_PLAY) || (state_d == ST_DYING) || (state_d == ST_SCORED);
    flash_d  = (state_d == ST_DYING);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      x_q      <= X_SPAWN;
      y_q      <= Y_SPAWN;
      lives_q  <= LIVES_INIT;
      score_q  <= '0;
      level_q  <= '0;
      cd_q     <= '0;
      tm_q     <= '0;
      active_q <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed from the previous clock, independent of statement order.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      level_q  <= level_d;
      cd_q     <= cd_d;
      tm_q     <= tm_d;
      active_q <= active_d;
      flash_q  <= flash_d;
    end
  end

  assign bus.o_Frogger_X   = x_q;
  assign bus.o_Frogger_Y   = y_q;
  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = active_q;
  assign bus.o_Death_Flash = flash_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Score       = score_q;
  assign bus.o_Level       = level_q;

endmodule

// File: tb/tb_frogger_game_seq.sv
// -----------------------------------------------------------------------------
// tb_frogger_game_seq
//
// Directed scenarios plus a randomized run for frogger_game_seq. Expected
// values come from constants and from a behavioural model that tracks the
// game with plain integers: moves are gated by the clock index at which the
// next move becomes legal, and DYING/SCORED end at an absolute clock index.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_frogger_game_seq;

  localparam int MOVE_CD     = 4;
  localparam int DEATH       = 8;
  localparam int SCORE       = 6;
  localparam int GRID_W      = 20;
  localparam int GRID_H      = 15;
  localparam int START_X     = 10;
  localparam int START_Y     = 14;
  localparam int START_LIVES = 3;

  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_SCORED = 3, M_OVER = 4;

  localparam logic [3:0] D_NONE = 4'b0000;
  localparam logic [3:0] D_UP   = 4'b1000;
  localparam logic [3:0] D_DN   = 4'b0100;
  localparam logic [3:0] D_LF   = 4'b0010;
  localparam logic [3:0] D_RT   = 4'b0001;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;

  frogger_game_seq_if bus ();

  frogger_game_seq #(
    .GRID_W        (GRID_W),
    .GRID_H        (GRID_H),
    .START_X       (START_X),
    .START_Y       (START_Y),
    .START_LIVES   (START_LIVES),
    .MOVE_COOLDOWN (MOVE_CD),
    .DEATH_CYCLES  (DEATH),
    .SCORE_CYCLES  (SCORE)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // {state, x, y, lives, score, level, active, flash}
  logic [28:0] dut_vec;
  assign dut_vec = {bus.o_State, bus.o_Frogger_X, bus.o_Frogger_Y, bus.o_Lives,
                    bus.o_Score, bus.o_Level, bus.o_Game_Active, bus.o_Death_Flash};

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_state, m_x, m_y, m_lives, m_score, m_level;
  int m_cyc, m_next_move, m_phase_end;

  function automatic logic [28:0] mk(input int s, input int x, input int y,
                                     input int l, input int sc, input int lv);
    logic act, fl;
    act = (s == M_PLAY || s == M_DYING || s == M_SCORED);
    fl  = (s == M_DYING);
    return {3'(s), 6'(x), 6'(y), 2'(l), 7'(sc), 3'(lv), act, fl};
  endfunction

  function automatic logic [28:0] model_vec();
    return mk(m_state, m_x, m_y, m_lives, m_score, m_level);
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_x = START_X; m_y = START_Y; m_lives = START_LIVES;
    m_score = 0; m_level = 0; m_cyc = 0; m_next_move = 0; m_phase_end = 0;
  endfunction

  function automatic void model_respawn();
    m_state = M_PLAY; m_x = START_X; m_y = START_Y; m_next_move = m_cyc + 1;
  endfunction

  function automatic void model_new_game();
    m_lives = START_LIVES; m_score = 0; m_level = 0;
    model_respawn();
  endfunction

  // Advances the model across one rising edge with the given inputs.
  function automatic void model_step(input logic st, input logic [3:0] dir, input logic hz);
    int nx, ny;
    m_cyc++;
    case (m_state)
      M_IDLE: if (st) model_new_game();
      M_PLAY: begin
        if (hz) begin
          m_state = M_DYING;
          if (m_lives > 0) m_lives--;
          m_phase_end = m_cyc + DEATH;
        end else if (m_y == 0) begin
          m_state = M_SCORED;
          m_score = (m_score < 99) ? m_score + 1 : 99;
          m_level = (m_level < 7) ? m_level + 1 : 7;
          m_phase_end = m_cyc + SCORE;
        end else if (dir != D_NONE && m_cyc >= m_next_move) begin
          nx = m_x; ny = m_y;
          if (dir[3])      ny = ny - 1;
          else if (dir[2]) ny = ny + 1;
          else if (dir[1]) nx = nx - 1;
          else             nx = nx + 1;
          if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
            m_x = nx; m_y = ny;
          end
          m_next_move = m_cyc + MOVE_CD;
        end
      end
      M_DYING: if (m_cyc == m_phase_end) begin
        if (m_lives == 0) m_state = M_OVER;
        else model_respawn();
      end
      M_SCORED: if (m_cyc == m_phase_end) model_respawn();
      M_OVER: if (st) model_new_game();
      default: ;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at the next one)
  // ---------------------------------------------------------------------------
  task automatic tick(input logic st, input logic [3:0] dir, input logic hz);
    bus.i_Start      = st;
    bus.i_Up_Mvt     = dir[3];
    bus.i_Down_Mvt   = dir[2];
    bus.i_Left_Mvt   = dir[1];
    bus.i_Right_Mvt  = dir[0];
    bus.i_Hazard_Hit = hz;
    model_step(st, dir, hz);
    @(negedge i_Clk);
    bus.i_Start = 1'b0; bus.i_Up_Mvt = 1'b0; bus.i_Down_Mvt = 1'b0;
    bus.i_Left_Mvt = 1'b0; bus.i_Right_Mvt = 1'b0; bus.i_Hazard_Hit = 1'b0;
  endtask

  // One move request followed by idle clocks until the cooldown has run out.
  task automatic step(input logic [3:0] dir);
    tick(1'b0, dir, 1'b0);
    repeat (MOVE_CD - 1) tick(1'b0, D_NONE, 1'b0);
  endtask

  task automatic run_goal();
    repeat (START_Y) step(D_UP);
    for (int i = 0; i < 20 && m_state != M_PLAY; i++) tick(1'b0, D_NONE, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [28:0] exp;
    i_Rst_L = 1'b0;
    tick(1'b0, D_NONE, 1'b0);
    model_reset();
    exp = mk(M_IDLE, START_X, START_Y, START_LIVES, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL reset_values: got %h expected %h", dut_vec, exp);
    end
    i_Rst_L = 1'b1;
    tick(1'b0, D_UP, 1'b1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL idle_holds: got %h expected %h", dut_vec, exp);
    end
  endtask

  task automatic test_start();
    logic [28:0] exp;
    tick(1'b1, D_NONE, 1'b0);
    exp = mk(M_PLAY, 10, 14, 3, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL start_play: got %h expected %h", dut_vec, exp);
    end
  endtask

  task automatic test_up_hold();
    int exp_y;
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, D_UP, 1'b0);
      exp_y = 14 - ((i >= 1) ? 1 : 0) - ((i >= 5) ? 1 : 0) - ((i >= 9) ? 1 : 0);
      tests_run++;
      if (bus.o_Frogger_Y !== 6'(exp_y)) begin
        tests_failed++;
        $display("FAIL up_hold clk %0d: y=%0d expected %0d", i, bus.o_Frogger_Y, exp_y);
      end
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_NONE, 1'b0);
    step(D_UP | D_LF);
    tests_run++;
    if (bus.o_Frogger_X !== 6'd10 || bus.o_Frogger_Y !== 6'd10) begin
      tests_failed++;
      $display("FAIL up_left_priority: x=%0d y=%0d expected x=10 y=10",
               bus.o_Frogger_X, bus.o_Frogger_Y);
    end
  endtask

  task automatic test_blocked();
    repeat (9) step(D_RT);
    tick(1'b0, D_RT, 1'b0);
    tests_run++;
    if (bus.o_Frogger_X !== 6'd19 || bus.o_State !== 3'd1) begin
      tests_failed++; $display("FAIL right_edge: x=%0d expected 19", bus.o_Frogger_X);
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_LF, 1'b0);
    tests_run++;
    if (bus.o_Frogger_X !== 6'd19) begin
      tests_failed++; $display("FAIL blocked_reload: x=%0d expected 19", bus.o_Frogger_X);
    end
    tick(1'b0, D_LF, 1'b0);
    tests_run++;
    if (bus.o_Frogger_X !== 6'd18) begin
      tests_failed++; $display("FAIL left_after_reload: x=%0d expected 18", bus.o_Frogger_X);
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_NONE, 1'b0);
    repeat (4) step(D_DN);
    tick(1'b0, D_DN, 1'b0);
    tests_run++;
    if (bus.o_Frogger_Y !== 6'd14) begin
      tests_failed++; $display("FAIL bottom_edge: y=%0d expected 14", bus.o_Frogger_Y);
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_UP, 1'b0);
    tests_run++;
    if (bus.o_Frogger_Y !== 6'd14) begin
      tests_failed++; $display("FAIL down_blocked_reload: y=%0d expected 14", bus.o_Frogger_Y);
    end
    tick(1'b0, D_UP, 1'b0);
    tests_run++;
    if (bus.o_Frogger_Y !== 6'd13) begin
      tests_failed++; $display("FAIL up_after_reload: y=%0d expected 13", bus.o_Frogger_Y);
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_NONE, 1'b0);
    repeat (18) step(D_LF);
    tick(1'b0, D_LF, 1'b0);
    tests_run++;
    if (bus.o_Frogger_X !== 6'd0 || bus.o_Frogger_Y !== 6'd13) begin
      tests_failed++;
      $display("FAIL left_edge: x=%0d y=%0d expected x=0 y=13", bus.o_Frogger_X, bus.o_Frogger_Y);
    end
    repeat (MOVE_CD - 1) tick(1'b0, D_NONE, 1'b0);
  endtask

  task automatic test_hazard();
    logic [28:0] exp;
    int px, py;
    px = m_x; py = m_y;
    tick(1'b0, D_UP, 1'b1);
    exp = mk(M_DYING, px, py, 2, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL hazard_hit: got %h expected %h", dut_vec, exp);
    end
    for (int i = 1; i < DEATH; i++) begin
      tick(1'b0, 4'($urandom), 1'(i % 2));
      tests_run++;
      if (dut_vec !== exp) begin
        tests_failed++; $display("FAIL dying_hold clk %0d: got %h expected %h", i, dut_vec, exp);
      end
    end
    tick(1'b0, D_NONE, 1'b0);
    exp = mk(M_PLAY, 10, 14, 2, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL dying_exit: got %h expected %h", dut_vec, exp);
    end
  endtask

  task automatic test_goal();
    logic [28:0] exp;
    repeat (13) step(D_UP);
    tick(1'b0, D_UP, 1'b0);
    exp = mk(M_PLAY, 10, 0, 2, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL reach_goal: got %h expected %h", dut_vec, exp);
    end
    tick(1'b0, D_NONE, 1'b0);
    exp = mk(M_SCORED, 10, 0, 2, 1, 1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL scored: got %h expected %h", dut_vec, exp);
    end
    repeat (SCORE - 1) tick(1'b1, D_DN, 1'b1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL scored_hold: got %h expected %h", dut_vec, exp);
    end
    tick(1'b0, D_NONE, 1'b0);
    exp = mk(M_PLAY, 10, 14, 2, 1, 1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL scored_exit: got %h expected %h", dut_vec, exp);
    end
    tick(1'b1, D_NONE, 1'b0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL start_in_play: got %h expected %h", dut_vec, exp);
    end
  endtask

  task automatic test_score_saturation();
    logic [28:0] exp;
    for (int g = 0; g < 98; g++) begin
      run_goal();
      tests_run++;
      if (dut_vec !== model_vec()) begin
        tests_failed++;
        $display("FAIL goal %0d: got %h expected %h", g + 2, dut_vec, model_vec());
      end
    end
    exp = mk(M_PLAY, 10, 14, 2, 99, 7);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL score_99: got %h expected %h", dut_vec, exp);
    end
    run_goal();
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL score_saturate: got %h expected %h", dut_vec, exp);
    end
  endtask

  task automatic test_game_over();
    logic [28:0] exp;
    for (int h = 0; h < 2; h++) begin
      step(D_LF);
      tick(1'b0, D_NONE, 1'b1);
      repeat (DEATH) tick(1'b0, D_NONE, 1'b0);
    end
    exp = mk(M_OVER, 9, 14, 0, 99, 7);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL game_over: got %h expected %h", dut_vec, exp);
    end
    tick(1'b0, D_UP, 1'b1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL game_over_hold: got %h expected %h", dut_vec, exp);
    end
    tick(1'b1, D_NONE, 1'b0);
    exp = mk(M_PLAY, 10, 14, 3, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL restart: got %h expected %h", dut_vec, exp);
    end
    for (int h = 0; h < 3; h++) begin
      tick(1'b0, D_NONE, 1'b1);
      tests_run++;
      if (bus.o_Lives !== 2'(2 - h) || bus.o_State !== 3'd2) begin
        tests_failed++;
        $display("FAIL hit %0d: lives=%0d state=%0d expected lives=%0d state=2",
                 h + 1, bus.o_Lives, bus.o_State, 2 - h);
      end
      repeat (DEATH) tick(1'b0, D_NONE, 1'b0);
    end
    exp = mk(M_OVER, 10, 14, 0, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL three_hits: got %h expected %h", dut_vec, exp);
    end
    tick(1'b1, D_NONE, 1'b0);
  endtask

  task automatic test_random();
    logic       st, hz;
    logic [3:0] dir;
    for (int i = 0; i < 1500; i++) begin
      st  = ($urandom_range(0, 15) == 0);
      hz  = ($urandom_range(0, 59) == 0);
      dir = 4'($urandom);
      if ($urandom_range(0, 2) == 0) dir[3] = 1'b1;
      tick(st, dir, hz);
      tests_run++;
      if (dut_vec !== model_vec()) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid_dying();
    logic [28:0] exp;
    for (int i = 0; i < 40 && m_state != M_PLAY; i++) tick(1'b1, D_NONE, 1'b0);
    tick(1'b0, D_NONE, 1'b1);
    repeat (3) tick(1'b0, D_NONE, 1'b0);
    tests_run++;
    if (bus.o_State !== 3'd2 || bus.o_Death_Flash !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_dying: state=%0d flash=%0b expected state=2 flash=1",
               bus.o_State, bus.o_Death_Flash);
    end
    #2 i_Rst_L = 1'b0;
    #1;
    model_reset();
    exp = mk(M_IDLE, START_X, START_Y, START_LIVES, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL async_reset: got %h expected %h", dut_vec, exp);
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    tick(1'b0, D_UP, 1'b1);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL idle_after_reset: got %h expected %h", dut_vec, exp);
    end
    tick(1'b1, D_NONE, 1'b0);
    exp = mk(M_PLAY, 10, 14, 3, 0, 0);
    tests_run++;
    if (dut_vec !== exp) begin
      tests_failed++; $display("FAIL start_after_reset: got %h expected %h", dut_vec, exp);
    end
  endtask

  initial begin
    bus.i_Start = 1'b0; bus.i_Up_Mvt = 1'b0; bus.i_Down_Mvt = 1'b0;
    bus.i_Left_Mvt = 1'b0; bus.i_Right_Mvt = 1'b0; bus.i_Hazard_Hit = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_up_hold();
    test_blocked();
    test_hazard();
    test_goal();
    test_score_saturation();
    test_game_over();
    test_random();
    test_reset_mid_dying();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
